// File: rtl/i2c_master_arbiter.sv
// Two-requester round-robin arbiter that serialises transactions onto one shared I2C master.
// Optional WAIT watchdog enabled by defining I2C_ARB_TIMEOUT_EN (abort after TIMEOUT_CYC cycles).
module i2c_master_arbiter #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] req_wr,
  input  logic [6:0] req_addr0,
  input  logic [6:0] req_addr1,
  input  logic [7:0] req_din0,
  input  logic [7:0] req_din1,
  output logic [1:0] gnt,
  output logic [1:0] rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy,
  output logic       m_start,
  output logic       m_wr,
  output logic [6:0] m_addr,
  output logic [7:0] m_din,
  input  logic       m_done,
  input  logic [7:0] m_dout,
  input  logic       m_nack
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;

  if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 65535)) begin : g_bad_timeout
    $error("TIMEOUT_CYC out of range 2..65535");
  end

  logic [2:0] r_state;
  logic [1:0] r_gnt;
  logic [1:0] r_rsp_valid;
  logic [7:0] r_rsp_data;
  logic       r_rsp_err;
  logic       r_owner;
  logic       r_last;
  logic       r_m_start;
  logic       r_m_wr;
  logic [6:0] r_m_addr;
  logic [7:0] r_m_din;
  logic       w_sel;
  logic       w_tmo;

  // On contention the requester that did not win last time is chosen.
  assign w_sel = (req == 2'b11) ? ~r_last : req[1];

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;

  assign w_tmo = (r_tmo_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_WAIT) && !m_done && !w_tmo) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_m_start   <= 1'b0;
      r_m_wr      <= 1'b0;
      r_m_addr    <= '0;
      r_m_din     <= '0;
    end else begin
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_m_start   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_owner  <= w_sel;
            r_gnt    <= w_sel ? 2'b10 : 2'b01;
            r_m_wr   <= req_wr[w_sel];
            r_m_addr <= w_sel ? req_addr1 : req_addr0;
            r_m_din  <= w_sel ? req_din1 : req_din0;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_m_start <= 1'b1;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          // A completion in the same cycle as the watchdog expiry takes precedence.
          if (m_done) begin
            r_rsp_data  <= r_m_wr ? 8'h00 : m_dout;
            r_rsp_err   <= m_nack;
            r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
            r_state     <= S_RESP;
          end else if (w_tmo) begin
            r_rsp_data  <= 8'h00;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          r_last  <= r_owner;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != S_IDLE);
  assign m_start   = r_m_start;
  assign m_wr      = r_m_wr;
  assign m_addr    = r_m_addr;
  assign m_din     = r_m_din;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: vector table of complete transactions plus
// hand sequences for reset, idle noise, watchdog (I2C_ARB_TIMEOUT_EN) and reset in WAIT.
module tb_i2c_master_arbiter;

  typedef struct {
    logic [1:0] req;
    logic [1:0] wr;
    logic [6:0] addr0;
    logic [6:0] addr1;
    logic [7:0] din0;
    logic [7:0] din1;
    logic [7:0] dout;
    logic       nack;
    logic       hold;
    logic [1:0] expGnt;
    logic [6:0] expAddr;
    logic [7:0] expDin;
    logic       expWr;
    logic [1:0] expRsp;
    logic [7:0] expData;
    logic       expErr;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] req_wr;
  logic [6:0] req_addr0;
  logic [6:0] req_addr1;
  logic [7:0] req_din0;
  logic [7:0] req_din1;
  logic [1:0] gnt;
  logic [1:0] rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic       m_start;
  logic       m_wr;
  logic [6:0] m_addr;
  logic [7:0] m_din;
  logic       m_done;
  logic [7:0] m_dout;
  logic       m_nack;

  int nVectors;
  int nMiscompares;
  vec_t vecs [12];

  i2c_master_arbiter #(.TIMEOUT_CYC(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr0 (req_addr0),
    .req_addr1 (req_addr1),
    .req_din0  (req_din0),
    .req_din1  (req_din1),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .m_start   (m_start),
    .m_wr      (m_wr),
    .m_addr    (m_addr),
    .m_din     (m_din),
    .m_done    (m_done),
    .m_dout    (m_dout),
    .m_nack    (m_nack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_gnt"}, 32'(gnt), 32'd0);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_m_start"}, 32'(m_start), 32'd0);
    checkOutput({tag, "_m_wr"}, 32'(m_wr), 32'd0);
    checkOutput({tag, "_m_addr"}, 32'(m_addr), 32'd0);
    checkOutput({tag, "_m_din"}, 32'(m_din), 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    req       = v.req;
    req_wr    = v.wr;
    req_addr0 = v.addr0;
    req_addr1 = v.addr1;
    req_din0  = v.din0;
    req_din1  = v.din1;
  endtask

  task automatic applyReset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One full transaction starting at a negedge with the arbiter idle.
  task automatic runVector(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    applyStimulus(v);
    @(negedge clk);
    checkOutput({p, "_gnt"}, 32'(gnt), 32'(v.expGnt));
    checkOutput({p, "_busy_gnt"}, 32'(busy), 32'd1);
    checkOutput({p, "_start_early"}, 32'(m_start), 32'd0);
    if (!v.hold) req = req & ~v.expGnt;
    @(negedge clk);
    checkOutput({p, "_m_start"}, 32'(m_start), 32'd1);
    checkOutput({p, "_gnt_pulse"}, 32'(gnt), 32'd0);
    checkOutput({p, "_m_addr"}, 32'(m_addr), 32'(v.expAddr));
    checkOutput({p, "_m_din"}, 32'(m_din), 32'(v.expDin));
    checkOutput({p, "_m_wr"}, 32'(m_wr), 32'(v.expWr));
    m_done = 1'b1;
    m_dout = v.dout;
    m_nack = v.nack;
    @(negedge clk);
    checkOutput({p, "_rsp_valid"}, 32'(rsp_valid), 32'(v.expRsp));
    checkOutput({p, "_rsp_data"}, 32'(rsp_data), 32'(v.expData));
    checkOutput({p, "_rsp_err"}, 32'(rsp_err), 32'(v.expErr));
    checkOutput({p, "_busy_resp"}, 32'(busy), 32'd1);
    checkOutput({p, "_m_addr_hold"}, 32'(m_addr), 32'(v.expAddr));
    checkOutput({p, "_m_start_pulse"}, 32'(m_start), 32'd0);
    m_done = 1'b0;
    m_nack = 1'b0;
    @(negedge clk);
    checkOutput({p, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
    checkOutput({p, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    bit seen;

    nVectors     = 0;
    nMiscompares = 0;
    rst          = 1'b0;
    req          = '0;
    req_wr       = '0;
    req_addr0    = '0;
    req_addr1    = '0;
    req_din0     = '0;
    req_din1     = '0;
    m_done       = 1'b0;
    m_dout       = '0;
    m_nack       = 1'b0;

    //          req   wr    a0     a1     d0     d1     dout   nk    hold  gnt   eAddr  eDin   eWr   eRsp  eData  eErr
    vecs[0]  = '{2'b11, 2'b01, 7'h50, 7'h21, 8'hA5, 8'h5A, 8'h3C, 1'b0, 1'b1, 2'b01, 7'h50, 8'hA5, 1'b1, 2'b01, 8'h00, 1'b0};
    vecs[1]  = '{2'b11, 2'b01, 7'h50, 7'h21, 8'hA5, 8'h5A, 8'h3C, 1'b0, 1'b1, 2'b10, 7'h21, 8'h5A, 1'b0, 2'b10, 8'h3C, 1'b0};
    vecs[2]  = '{2'b11, 2'b01, 7'h50, 7'h21, 8'hA5, 8'h5A, 8'h3C, 1'b0, 1'b1, 2'b01, 7'h50, 8'hA5, 1'b1, 2'b01, 8'h00, 1'b0};
    vecs[3]  = '{2'b01, 2'b01, 7'h50, 7'h00, 8'hA5, 8'h00, 8'hFF, 1'b0, 1'b0, 2'b01, 7'h50, 8'hA5, 1'b1, 2'b01, 8'h00, 1'b0};
    vecs[4]  = '{2'b10, 2'b00, 7'h00, 7'h21, 8'h00, 8'h00, 8'h3C, 1'b0, 1'b0, 2'b10, 7'h21, 8'h00, 1'b0, 2'b10, 8'h3C, 1'b0};
    vecs[5]  = '{2'b01, 2'b01, 7'h3A, 7'h00, 8'h11, 8'h00, 8'h00, 1'b1, 1'b0, 2'b01, 7'h3A, 8'h11, 1'b1, 2'b01, 8'h00, 1'b1};
    vecs[6]  = '{2'b10, 2'b10, 7'h00, 7'h68, 8'h00, 8'hC3, 8'hAB, 1'b0, 1'b0, 2'b10, 7'h68, 8'hC3, 1'b1, 2'b10, 8'h00, 1'b0};
    vecs[7]  = '{2'b01, 2'b00, 7'h2D, 7'h00, 8'h00, 8'h00, 8'h9E, 1'b1, 1'b0, 2'b01, 7'h2D, 8'h00, 1'b0, 2'b01, 8'h9E, 1'b1};
    vecs[8]  = '{2'b11, 2'b00, 7'h11, 7'h22, 8'h01, 8'h02, 8'h44, 1'b0, 1'b0, 2'b10, 7'h22, 8'h02, 1'b0, 2'b10, 8'h44, 1'b0};
    vecs[9]  = '{2'b01, 2'b00, 7'h11, 7'h00, 8'h01, 8'h00, 8'h55, 1'b0, 1'b0, 2'b01, 7'h11, 8'h01, 1'b0, 2'b01, 8'h55, 1'b0};
    vecs[10] = '{2'b01, 2'b01, 7'h0F, 7'h00, 8'hF0, 8'h00, 8'h00, 1'b0, 1'b0, 2'b01, 7'h0F, 8'hF0, 1'b1, 2'b01, 8'h00, 1'b0};
    vecs[11] = '{2'b11, 2'b10, 7'h45, 7'h46, 8'h99, 8'h98, 8'h12, 1'b0, 1'b0, 2'b01, 7'h45, 8'h99, 1'b0, 2'b01, 8'h12, 1'b0};

    @(negedge clk);
    @(negedge clk);
    checkResetValues("reset");
    rst = 1'b1;

    // Idle noise: m_done outside WAIT and a sub-cycle req blip must do nothing.
    m_done = 1'b1;
    m_dout = 8'hEE;
    @(negedge clk);
    @(negedge clk);
    checkOutput("idle_done_rsp", 32'(rsp_valid), 32'd0);
    checkOutput("idle_done_busy", 32'(busy), 32'd0);
    m_done = 1'b0;
    req = 2'b01;
    #2;
    req = 2'b00;
    @(negedge clk);
    checkOutput("blip_gnt", 32'(gnt), 32'd0);
    checkOutput("blip_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 10; i++) runVector(i, vecs[i]);

    // Master never answers: watchdog abort, or a permanent WAIT without the watchdog.
    req       = 2'b01;
    req_wr    = 2'b00;
    req_addr0 = 7'h10;
    @(negedge clk);
    checkOutput("stall_gnt", 32'(gnt), 32'd1);
    req = 2'b00;
    @(negedge clk);
    checkOutput("stall_m_start", 32'(m_start), 32'd1);
    n    = 0;
    seen = 1'b0;
    while ((n < 20) && !seen) begin
      @(negedge clk);
      n++;
      if (rsp_valid != 2'b00) seen = 1'b1;
    end
`ifdef I2C_ARB_TIMEOUT_EN
    checkOutput("tmo_seen", 32'(seen), 32'd1);
    checkOutput("tmo_latency", 32'(n), 32'd8);
    checkOutput("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("tmo_rsp_err", 32'(rsp_err), 32'd1);
    checkOutput("tmo_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    checkOutput("tmo_busy_idle", 32'(busy), 32'd0);
`else
    checkOutput("stuck_no_rsp", 32'(seen), 32'd0);
    checkOutput("stuck_busy", 32'(busy), 32'd1);
    applyReset();
`endif

    runVector(10, vecs[10]);

    // Reset while waiting on the master: abort silently and restore requester-0 priority.
    req       = 2'b10;
    req_wr    = 2'b00;
    req_addr1 = 7'h33;
    req_din1  = 8'h7E;
    @(negedge clk);
    checkOutput("rw_gnt", 32'(gnt), 32'd2);
    req = 2'b00;
    @(negedge clk);
    checkOutput("rw_m_start", 32'(m_start), 32'd1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rw_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    checkResetValues("rw_async");
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) n++;
    end
    checkOutput("rw_no_rsp", 32'(n), 32'd0);
    checkOutput("rw_idle", 32'(busy), 32'd0);

    runVector(11, vecs[11]);
    req = 2'b00;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
